// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the RV64 integer datapath core: default sizes and ALU opcodes.
package alu_regfile_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        ALU_ADD0 = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SLTU = 2'b10,
        ALU_SUB  = 2'b11
    } aluop_t;

endpackage

// File: rtl/alu_regfile_rf.sv
// Architectural register file: x1..x31 stored, x0 reads zero, async clear on rst.
// Optional write-first read bypass when REGFILE_BYPASS_EN is defined.
module alu_regfile_rf
    import alu_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic            w_wr_ok;

    assign w_wr_ok = we && (waddr != '0);

    // NOTE: the whole array is cleared asynchronously because reset must be visible before any clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        if (addr != '0) begin
            v = r_regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && !rst && (addr == waddr)) begin
                v = wdata;
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: rtl/alu_regfile.sv
// Integer datapath core: register file plus combinational 64-bit ALU.
// Define REGFILE_BYPASS_EN for write-first reads of the register being written.
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [1:0]      aluop,
    output logic [XLEN-1:0] result
);

    aluop_t w_op;

    alu_regfile_rf #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    assign w_op = aluop_t'(aluop);

    // Both add encodings behave identically; carries fall off the top.
    always_comb begin
        result = '0;
        case (w_op)
            ALU_ADD0, ALU_ADD: result = src1 + src2;
            ALU_SLTU:          result = {{(XLEN-1){1'b0}}, (src1 < src2)};
            ALU_SUB:           result = src1 - src2;
            default:           result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed cases plus randomized traffic against an array model.
module tb_alu_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [63:0] rdata1, rdata2, wdata, src1, src2, result;
    logic        we;
    logic [1:0]  aluop;

    logic [63:0] model [32];
    bit          check_en;
    int          total;
    int          bad;

    alu_regfile dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .src1   (src1),
        .src2   (src2),
        .aluop  (aluop),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of architectural state: cleared by reset, one write per rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    end

    function automatic logic [63:0] exp_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    function automatic logic [63:0] exp_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd2:    return (a < b) ? 64'd1 : 64'd0;
            2'd3:    return a - b;
            default: return a + b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check("rdata1", rdata1, exp_read(raddr1));
            check("rdata2", rdata2, exp_read(raddr2));
            check("result", result, exp_alu(aluop, src1, src2));
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic alu_case(input string name, input logic [1:0] op,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        aluop = op; src1 = a; src2 = b;
        #1;
        check(name, result, exp);
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'(($urandom_range(0, 7)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] exp3;
        total = 0; bad = 0; check_en = 0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 64'd0;
        raddr1 = 5'd5; raddr2 = 5'd31; src1 = 64'd0; src2 = 64'd0; aluop = 2'b00;
        #3;
        check("reset_rd1", rdata1, 64'd0);
        check("reset_rd2", rdata2, 64'd0);
        next_cycle();
        rst = 1'b0;
        check_en = 1;

        // Async reset mid-cycle after x5 = 0x1234
        we = 1'b1; waddr = 5'd5; wdata = 64'h1234;
        next_cycle();
        we = 1'b0; raddr1 = 5'd5;
        #1 check("x5_written", rdata1, 64'h1234);
        #1 rst = 1'b1;
        #1 check("async_clear", rdata1, 64'd0);
        rst = 1'b0;

        // x10 write, then a disabled write must not change it
        next_cycle();
        we = 1'b1; waddr = 5'd10; wdata = 64'hDEADBEEF_00000001;
        next_cycle();
        we = 1'b0; wdata = 64'h5; raddr1 = 5'd10; raddr2 = 5'd10;
        #1;
        check("x10_port1", rdata1, 64'hDEADBEEF_00000001);
        check("x10_port2", rdata2, 64'hDEADBEEF_00000001);
        next_cycle();
        check("x10_kept", rdata1, 64'hDEADBEEF_00000001);

        // x0 write dropped
        we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        next_cycle();
        we = 1'b0;
        #1;
        check("x0_rd1", rdata1, 64'd0);
        check("x0_rd2", rdata2, 64'd0);

        // Read-during-write on x3: old value 2, new value 7
        next_cycle();
        we = 1'b1; waddr = 5'd3; wdata = 64'd2;
        next_cycle();
        wdata = 64'd7; raddr1 = 5'd3; raddr2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
        exp3 = 64'd7;
`else
        exp3 = 64'd2;
`endif
        #1 check("rdw_same_cycle", rdata1, exp3);
        next_cycle();
        we = 1'b0;
        #1 check("rdw_after_edge", rdata1, 64'd7);

        // ALU boundary cases
        alu_case("add01_wrap", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        alu_case("add00_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        alu_case("sub_wrap",   2'b11, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_case("sltu_lt",    2'b10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        alu_case("sltu_eq",    2'b10, 64'd5, 64'd5, 64'd0);
        alu_case("sltu_gt",    2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            rst   = ($urandom_range(0, 49) == 0);
            we    = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = rand64();
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            src1  = rand64();
            src2  = ($urandom_range(0, 4) == 0) ? src1 : rand64();
            aluop = 2'($urandom_range(0, 3));
        end
        next_cycle();
        rst = 1'b0; we = 1'b0;
        next_cycle();
        check_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Integer datapath core for the single-cycle RV64 CPU. It holds the 32×64-bit architectural register file (two combinational read ports, one synchronous write port, x0 hardwired to zero) and a combinational 64-bit ALU. The fetch/decode top level drives register addresses, write-back data and ALU operands. It consumes read data (branch compare, store data, `a0` halt value) and the ALU result (addresses, addi/sltiu/jalr results).

## Interface
- XLEN, 64, datapath width.
- NREG, 32, number of architectural registers; the address width is log2(NREG).
- clk  in  1  clock; the only clock.
- rst  in  1  reset. Asynchronous, active-high.
- raddr1  in  5  read port 1 address.
- rdata1  out  XLEN  read port 1 data.
- raddr2  in  5  read port 2 address.
- rdata2  out  XLEN  read port 2 data.
- we  in  1  write enable.
- waddr  in  5  write address.
- wdata  in  XLEN  write data.
- src1  in  XLEN  ALU operand 1.
- src2  in  XLEN  ALU operand 2.
- aluop  in  2  ALU operation select.
- result  out  XLEN  ALU result.

## Operation
- Registers x1..x31: 64-bit storage. x0 is not stored.
- Reads are combinational. A read of address 0 returns 0.
- Writes happen on the rising clk edge when `we` is 1 and `waddr` is not 0.
- A write with `waddr` = 0 is silently dropped and never alters any state.
- ALU is purely combinational; all arithmetic is modulo 2^XLEN and carries are discarded.
  - aluop 2'b00: result = src1 + src2 (default add).
  - aluop 2'b01: result = src1 + src2 (addi, jalr, store address).
  - aluop 2'b10: result = {63'b0, src1 < src2}, compared unsigned (sltiu).
  - aluop 2'b11: result = src1 − src2.
- The ALU and the register file are independent. `result` is not written back internally; the parent selects `wdata`.

## Timing
- Reset: asserting `rst` immediately clears x1..x31 to 0, independent of clk.
  - While `rst` is high, all writes are ignored.
  - `rdata1` and `rdata2` read 0 for every address.
  - Deassertion takes effect on the next clk edge with no extra latency.
- Reset asserted mid-write: clear wins; the register reads 0 afterwards.
- Write latency: one edge. The new value is visible on the read ports immediately after the edge.
- Read-during-write, same address in the same cycle: the read returns the old value unless REGFILE_BYPASS_EN is defined.
- Simultaneous reads of the same address on both ports return identical data.
- ALU result: zero-cycle combinational path, defined whenever the inputs are defined. `result` has no reset value and depends only on the inputs.

## Configuration
- REGFILE_BYPASS_EN defined: when `we` is 1, `waddr` is not 0 and `raddr` equals `waddr`, the corresponding `rdata` returns `wdata` combinationally (write-first).
  - This does not apply to address 0, and does not apply during `rst`.
- REGFILE_BYPASS_EN undefined: reads always return stored contents (read-old).

## Structure
- Shared package `alu_regfile_pkg` holds:
  - XLEN and NREG defaults.
  - The `aluop_t` 2-bit enum: ALU_ADD0 = 00, ALU_ADD = 01, ALU_SLTU = 10, ALU_SUB = 11.
- One sub-module, `alu_regfile_rf`, holds the register array, the reset logic and the optional bypass.
- The ALU is a combinational block in the parent.

## Test plan
- Reset with `rst` pulsed asynchronously mid-cycle after x5 was written with 0x1234 -> `rdata1` for raddr1 = 5 reads 0 immediately, before any clk edge.
- Write x10 = 0xDEADBEEF_00000001 with `we` = 1, then read on both ports -> both ports return 0xDEADBEEF_00000001 after the edge. With `we` = 0 and wdata 0x5 -> x10 is unchanged.
- Write x0 = 0xFFFF_FFFF_FFFF_FFFF -> raddr 0 still reads 0.
- Same-cycle write x3 = 7 while reading x3 (old value 2) -> reads 2 without REGFILE_BYPASS_EN, 7 with it. After the edge, both builds read 7.
- ALU add with src1 = 0xFFFF_FFFF_FFFF_FFFF, src2 = 1, aluop 01 and 00 -> result 0.
- ALU sub with aluop 11, src1 = 0, src2 = 1 -> result 0xFFFF_FFFF_FFFF_FFFF.
- ALU sltu with aluop 10:
  - src1 = 1, src2 = 0xFFFF_FFFF_FFFF_FFFF -> result 1.
  - src1 = 5, src2 = 5 -> result 0.
  - src1 = 0xFFFF_FFFF_FFFF_FFFF, src2 = 0 -> result 0.
